// File: rtl/sense_disable_gen_pkg.sv
// rtl/sense_disable_gen_pkg.sv - shared drivetrain types and constants for the sensor-disable producer
package sense_disable_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_t;

    localparam int LEFT         = 1;
    localparam int RIGHT        = 0;
    localparam int TRIP_COUNT_W = 8;
    localparam int WIN_TMR_W    = 27;
    localparam int WIN_CNT_W    = 4;
    localparam int DEB_CNT_W    = 16;

    function automatic logic [TRIP_COUNT_W-1:0] sat_inc(input logic [TRIP_COUNT_W-1:0] v);
        return (v == {TRIP_COUNT_W{1'b1}}) ? v : v + TRIP_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/sense_disable_gen_qualify.sv
// rtl/sense_disable_gen_qualify.sv - one trip channel: synchronizer, debounce, hold-off FSM
module sns_qualify
    import sense_disable_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_MIN_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic pause,
    output logic fire
);

    localparam int                    HOLD_W    = $clog2(HOLD_MIN_CYCLES + 1);
    localparam logic [DEB_CNT_W-1:0]  DEB_LAST  = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_MIN_CYCLES - 1);

    logic                 sync_meta;
    logic                 sync;
    chan_state_t          state;
    chan_state_t          state_nxt;
    logic [DEB_CNT_W-1:0] deb_cnt;
    logic [DEB_CNT_W-1:0] deb_cnt_nxt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [HOLD_W-1:0]    hold_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            state     <= ST_IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
            state     <= state_nxt;
            deb_cnt   <= deb_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
        end
    end

    // fire is the next-cycle pulse; the top registers it so the output stays a flop
    always_comb begin
        state_nxt    = state;
        deb_cnt_nxt  = deb_cnt;
        hold_cnt_nxt = hold_cnt;
        fire         = 1'b0;
        case (state)
            ST_IDLE: begin
                deb_cnt_nxt = '0;
                if (sync) begin
                    state_nxt = ST_QUAL;
                end
            end
            ST_QUAL: begin
                if (!sync) begin
                    state_nxt   = ST_IDLE;
                    deb_cnt_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    fire         = 1'b1;
                    state_nxt    = ST_HOLD;
                    deb_cnt_nxt  = '0;
                    hold_cnt_nxt = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + DEB_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                // pause and the line are ignored until the minimum hold has elapsed
                if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end else if (!pause && !sync) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/sense_disable_gen.sv
// rtl/sense_disable_gen.sv - two-channel trip pulse generator with trip-rate fault latch
module sense_disable_gen
    import sense_disable_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_MIN_CYCLES = 2,
    parameter int TRIP_LIMIT      = 3,
    parameter int WINDOW_CYCLES   = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              sns_raw,
    input  logic                    pause,
    input  logic                    fault_clr,
    output logic [1:0]              sns_disable,
    output logic                    fault,
    output logic [TRIP_COUNT_W-1:0] trip_count
);

    localparam logic [WIN_TMR_W-1:0] WIN_LAST  = WIN_TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_CNT_W-1:0] WIN_LIMIT = WIN_CNT_W'(TRIP_LIMIT);

    logic [1:0]           fire;
    logic [1:0]           pulse_q;
    logic                 event_hit;
    logic                 expired;
    logic                 fault_nxt;
    logic [WIN_CNT_W-1:0] win_cnt;
    logic [WIN_CNT_W-1:0] win_cnt_nxt;
    logic [WIN_CNT_W-1:0] win_base;
    logic [WIN_TMR_W-1:0] win_tmr;
    logic [WIN_TMR_W-1:0] win_tmr_nxt;

    sns_qualify #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_MIN_CYCLES (HOLD_MIN_CYCLES)
    ) u_left (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sns_raw[LEFT]),
        .pause (pause),
        .fire  (fire[LEFT])
    );

    sns_qualify #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_MIN_CYCLES (HOLD_MIN_CYCLES)
    ) u_right (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sns_raw[RIGHT]),
        .pause (pause),
        .fire  (fire[RIGHT])
    );

    // an event is the cycle the pulse is visible; both channels at once are one event
    assign event_hit = |pulse_q;
    assign expired   = (win_cnt != '0) && (win_tmr == WIN_LAST);
    assign win_base  = expired ? '0 : win_cnt;

    always_comb begin
        fault_nxt   = fault;
        win_cnt_nxt = win_cnt;
        win_tmr_nxt = win_tmr;
        if (fault) begin
            if (fault_clr) begin
                fault_nxt   = 1'b0;
                win_tmr_nxt = '0;
                win_cnt_nxt = event_hit ? WIN_CNT_W'(1) : '0;
            end
        end else begin
            if (expired) begin
                win_cnt_nxt = '0;
                win_tmr_nxt = '0;
            end else if (win_cnt != '0) begin
                win_tmr_nxt = win_tmr + WIN_TMR_W'(1);
            end
            if (event_hit) begin
                win_cnt_nxt = win_base + WIN_CNT_W'(1);
                if (win_base == '0) begin
                    win_tmr_nxt = '0;
                end
                if (win_cnt_nxt == WIN_LIMIT) begin
                    fault_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q     <= 2'b00;
            sns_disable <= 2'b00;
            fault       <= 1'b0;
            win_cnt     <= '0;
            win_tmr     <= '0;
            trip_count  <= '0;
        end else begin
            pulse_q     <= fire;
            sns_disable <= fault_nxt ? 2'b11 : fire;
            fault       <= fault_nxt;
            win_cnt     <= win_cnt_nxt;
            win_tmr     <= win_tmr_nxt;
            if (event_hit) begin
                trip_count <= sat_inc(trip_count);
            end
        end
    end

endmodule

// File: tb/tb_sense_disable_gen.sv
// tb/tb_sense_disable_gen.sv - scoreboard bench for sense_disable_gen
module tb_sense_disable_gen;

    localparam int DEB  = 8;
    localparam int HOLD = 2;
    localparam int LIM  = 3;
    localparam int WIN  = 200;

    typedef struct packed {
        logic [1:0] sd;
        logic       f;
        logic [7:0] tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sns_raw;
    logic       pause;
    logic       fault_clr;
    logic [1:0] sns_disable;
    logic       fault;
    logic [7:0] trip_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 0;
    exp_t q[$];

    bit [1:0] m_sy1, m_sy2, m_armed, m_pulse;
    int       m_run[2];
    int       m_age[2];
    bit       m_fault;
    int       m_wcnt, m_wstart, m_tc, m_edge;

    sense_disable_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_MIN_CYCLES (HOLD),
        .TRIP_LIMIT      (LIM),
        .WINDOW_CYCLES   (WIN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sns_raw     (sns_raw),
        .pause       (pause),
        .fault_clr   (fault_clr),
        .sns_disable (sns_disable),
        .fault       (fault),
        .trip_count  (trip_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_sy1 = 2'b00; m_sy2 = 2'b00; m_armed = 2'b11; m_pulse = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            m_run[ch] = 0;
            m_age[ch] = 0;
        end
        m_fault = 0; m_wcnt = 0; m_wstart = 0; m_tc = 0;
    endtask

    // Reference: a channel fires once DEB+1 consecutive synchronized-high samples
    // accumulate while armed; it re-arms HOLD samples later on a quiet, unpaused sample.
    task automatic model_step();
        exp_t     e;
        bit       evt;
        bit       s;
        bit [1:0] fire;
        evt  = |m_pulse;
        fire = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            s = m_sy2[ch];
            if (m_armed[ch]) begin
                m_run[ch] = s ? m_run[ch] + 1 : 0;
                if (m_run[ch] == DEB + 1) begin
                    fire[ch] = 1'b1; m_armed[ch] = 1'b0; m_age[ch] = 0; m_run[ch] = 0;
                end
            end else begin
                m_age[ch]++;
                if (m_age[ch] >= HOLD && !pause && !s) m_armed[ch] = 1'b1;
            end
            m_sy2[ch] = m_sy1[ch];
            m_sy1[ch] = sns_raw[ch];
        end
        if (m_fault) begin
            if (fault_clr) begin
                m_fault = 0; m_wcnt = evt ? 1 : 0; m_wstart = m_edge;
            end
        end else begin
            if (m_wcnt > 0 && m_edge - m_wstart == WIN) m_wcnt = 0;
            if (evt) begin
                if (m_wcnt == 0) m_wstart = m_edge;
                m_wcnt++;
                if (m_wcnt == LIM) m_fault = 1;
            end
        end
        if (evt && m_tc < 255) m_tc++;
        m_pulse = fire;
        m_edge++;
        e.sd = m_fault ? 2'b11 : fire;
        e.f  = m_fault;
        e.tc = 8'(m_tc);
        q.push_back(e);
    endtask

    initial begin
        exp_t r;
        r = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                q.delete();
                q.push_back(r);
            end else begin
                model_step();
            end
            mon_en = 1;
        end
    end

    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_checks++;
                got = {sns_disable, fault, trip_count};
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow t=%0t: no expected entry for sns_disable=%b fault=%b trip_count=%0d",
                             $time, sns_disable, fault, trip_count);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard t=%0t: got sns_disable=%b fault=%b trip_count=%0d, want sns_disable=%b fault=%b trip_count=%0d",
                                 $time, sns_disable, fault, trip_count, e.sd, e.f, e.tc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sns_raw = 2'b00; pause = 1'b0; fault_clr = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic trip_check(input string name, input logic [1:0] bits);
        sns_raw = bits;
        repeat (10) @(posedge clk);
        @(negedge clk); chk({name, "_early"}, sns_disable, 2'b00);
        @(posedge clk);
        @(negedge clk); chk({name, "_pulse"}, sns_disable, bits);
        @(posedge clk);
        @(negedge clk); chk({name, "_width"}, sns_disable, 2'b00);
    endtask

    initial begin
        int len;
        #1;
        do_reset();
        @(negedge clk);
        chk("reset_state", {sns_disable, fault, trip_count}, 11'd0);
        step(1);

        // glitch rejection
        sns_raw = 2'b01; step(7);
        sns_raw = 2'b00; step(1);
        sns_raw = 2'b01; step(7);
        sns_raw = 2'b00; step(10);
        @(negedge clk); chk("glitch_count", trip_count, 0);
        step(1);

        // basic trip
        do_reset();
        trip_check("basic", 2'b10);
        chk("basic_count", trip_count, 1);
        step(1);
        sns_raw = 2'b00; step(6);

        // hold-off under pause
        do_reset();
        trip_check("holdoff_first", 2'b10);
        pause = 1'b1;
        step(29); sns_raw = 2'b00;
        step(21); pause = 1'b0;
        step(5);
        @(negedge clk); chk("holdoff_no_second", trip_count, 1);
        step(1);
        trip_check("holdoff_requal", 2'b10);
        chk("holdoff_count", trip_count, 2);
        step(1);
        sns_raw = 2'b00; step(6);

        // simultaneous trips
        do_reset();
        trip_check("both", 2'b11);
        chk("both_count", trip_count, 1);
        step(1);
        sns_raw = 2'b00; step(6);

        // rate fault, clear, then spaced events
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sns_raw = 2'b01; step(12);
            sns_raw = 2'b00; step(4);
        end
        @(negedge clk);
        chk("fault_set", fault, 1);
        chk("fault_override", sns_disable, 2'b11);
        chk("fault_count", trip_count, 3);
        step(6);
        @(negedge clk); chk("fault_held", {fault, sns_disable}, 3'b111);
        step(1);
        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        @(negedge clk); chk("fault_clear", {fault, sns_disable}, 3'b000);
        step(1);
        for (int i = 0; i < 3; i++) begin
            sns_raw = 2'b01; step(12);
            sns_raw = 2'b00; step(238);
        end
        @(negedge clk);
        chk("spaced_no_fault", fault, 0);
        chk("spaced_count", trip_count, 6);
        step(1);

        // reset during qualification
        do_reset();
        sns_raw = 2'b10;
        step(8);
        rst_n = 1'b0;
        @(negedge clk); chk("midqual_reset", {sns_disable, fault, trip_count}, 11'd0);
        step(3);
        rst_n = 1'b1;
        trip_check("midqual_requal", 2'b10);
        step(1);
        sns_raw = 2'b00; step(6);

        // randomized traffic against the reference model
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            if (seg == 150) do_reset();
            len     = $urandom_range(1, 25);
            sns_raw = 2'($urandom_range(0, 3));
            pause   = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < len; k++) begin
                fault_clr = ($urandom_range(0, 30) == 0);
                step(1);
            end
            fault_clr = 1'b0;
        end
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
